// File: rtl/collision_score_if.sv
// Game-logic bundle between the playfield driver and collision_score:
// bird/column geometry and tick events in, game status and BCD scores out.
interface collision_score_if;
    logic        start;
    logic [10:0] birdY;
    logic [10:0] Ax;
    logic [10:0] Ay;
    logic [10:0] Bx;
    logic [10:0] By;
    logic        passColumn;
    logic        finished;
    logic        playing;
    logic        collision;
    logic [15:0] score;
    logic [15:0] highScore;

    modport master (
        output start, birdY, Ax, Ay, Bx, By, passColumn,
        input  finished, playing, collision, score, highScore
    );

    modport slave (
        input  start, birdY, Ax, Ay, Bx, By, passColumn,
        output finished, playing, collision, score, highScore
    );
endinterface

// File: rtl/collision_score.sv
// IDLE/PLAY/DEAD game FSM with bird-vs-column/floor hit detection and BCD scoring.
// High-score tracking is built only when COLLISION_SCORE_HIGHSCORE_EN is defined.
module collision_score #(
    parameter int SCREEN_HEIGHT = 480,
    parameter int COL_W         = 80,
    parameter int GAP_HALF      = 50,
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 16
) (
    input  logic               gameClk,
    input  logic               reset,
    collision_score_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [11:0] L_X_MIN   = 12'(BIRD_X);
    localparam logic [11:0] L_X_MAX   = 12'(BIRD_X + BIRD_SIZE + COL_W - 2);
    localparam logic [11:0] L_GAP     = 12'(GAP_HALF);
    localparam logic [11:0] L_SIZE_M1 = 12'(BIRD_SIZE - 1);
    localparam logic [11:0] L_FLOOR   = 12'(SCREEN_HEIGHT - 1);

    // Both bounds are compared against X directly so X=0 cannot underflow.
    function automatic logic col_overlap(input logic [11:0] x);
        return (x >= L_X_MIN) && (x <= L_X_MAX);
    endfunction

    function automatic logic col_hit(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] top, input logic [11:0] bot);
        return col_overlap(x) && (((top + L_GAP) < y) || (bot > (y + L_GAP)));
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_playing;
    logic        r_finished;
    logic        r_collision;
    logic        w_collision_next;
    logic [15:0] r_score;
    logic [15:0] w_score_next;
    logic [11:0] w_top;
    logic [11:0] w_bot;
    logic        w_hit;

    assign w_top = {1'b0, bus.birdY};
    assign w_bot = w_top + L_SIZE_M1;
    assign w_hit = col_hit({1'b0, bus.Ax}, {1'b0, bus.Ay}, w_top, w_bot)
                 | col_hit({1'b0, bus.Bx}, {1'b0, bus.By}, w_top, w_bot)
                 | (w_bot >= L_FLOOR);

    // Next state, next score and next collision flag.
    always_comb begin
        w_next           = r_state;
        w_score_next     = r_score;
        w_collision_next = r_collision;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next       = S_PLAY;
                    w_score_next = 16'h0000;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PLAY: begin
                // A hit on the same tick as a column pass freezes the score.
                if (w_hit) begin
                    w_next           = S_DEAD;
                    w_collision_next = 1'b1;
                end else if (bus.passColumn) begin
                    w_score_next = bcd_inc(r_score);
                end else begin
                    w_next = S_PLAY;
                end
            end
            S_DEAD: begin
                if (bus.start) begin
                    w_next           = S_PLAY;
                    w_score_next     = 16'h0000;
                    w_collision_next = 1'b0;
                end else begin
                    w_next = S_DEAD;
                end
            end
            default: begin
                w_next           = S_IDLE;
                w_score_next     = 16'h0000;
                w_collision_next = 1'b0;
            end
        endcase
    end

    // State, status flags and score registers.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_playing   <= 1'b0;
            r_finished  <= 1'b0;
            r_collision <= 1'b0;
            r_score     <= 16'h0000;
        end else begin
            r_state     <= w_next;
            r_playing   <= (w_next == S_PLAY);
            r_finished  <= (w_next == S_DEAD);
            r_collision <= w_collision_next;
            r_score     <= w_score_next;
        end
    end

    assign bus.playing   = r_playing;
    assign bus.finished  = r_finished;
    assign bus.collision = r_collision;
    assign bus.score     = r_score;

`ifdef COLLISION_SCORE_HIGHSCORE_EN
    logic [15:0] r_high;

    // Most-significant differing digit decides.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt   = (a[4*i +: 4] > b[4*i +: 4]);
                done = 1'b1;
            end else begin
                gt   = gt;
                done = done;
            end
        end
        return gt;
    endfunction

    // Best score is captured on the PLAY->DEAD edge.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            r_high <= 16'h0000;
        end else if ((r_state == S_PLAY) && w_hit && bcd_gt(r_score, r_high)) begin
            r_high <= r_score;
        end else begin
            r_high <= r_high;
        end
    end

    assign bus.highScore = r_high;
`else
    assign bus.highScore = 16'h0000;
`endif

endmodule

// File: doc/collision_score.md
COLLISION_SCORE -- requirements
Module: collision_score

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_HEIGHT, 480, playfield height in pixels.
- COL_W, 80, column width in pixels.
- GAP_HALF, 50, half-height of the column gap.
- BIRD_X, 200, bird left edge in column x-coordinates.
- BIRD_SIZE, 16, bird square side in pixels.

REQ-002 Ports (name, direction, width, meaning), one per line:
- gameClk, in, 1, game tick clock.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle start/restart request.
- birdY, in, 11, bird top edge y.
- Ax, in, 11, right edge x of column A.
- Ay, in, 11, gap centre y of column A.
- Bx, in, 11, right edge x of column B.
- By, in, 11, gap centre y of column B.
- passColumn, in, 1, a column has left the screen this tick.
- finished, out, 1, game over; drives the column generator's finished input.
- playing, out, 1, FSM is in PLAY.
- collision, out, 1, registered hit flag.
- score, out, 16, 4-digit BCD score.
- highScore, out, 16, 4-digit BCD best score.

Function
REQ-003 FSM states SHALL be IDLE, PLAY and DEAD, with playing=(PLAY) and finished=(DEAD), both driven from state registers.
REQ-004 IDLE->PLAY SHALL occur on start=1; the same edge clears score to 0000.
REQ-005 PLAY->DEAD SHALL occur on the first edge at which hit (REQ-008) is 1; collision rises on that same edge and holds until leaving DEAD.
REQ-006 DEAD->PLAY SHALL occur on start=1; the same edge clears score and collision.
REQ-007 A column (X,Y) overlaps horizontally iff X >= BIRD_X and X <= BIRD_X+BIRD_SIZE+COL_W-2.
- Computed without subtraction from X, so no underflow occurs at X=0.
REQ-008 hit SHALL be 1 iff any of the following holds:
- A column overlaps horizontally and (birdY+GAP_HALF < Y, or birdY+BIRD_SIZE-1 > Y+GAP_HALF).
- birdY+BIRD_SIZE-1 >= SCREEN_HEIGHT-1 (floor).
REQ-009 All REQ-008 comparisons SHALL use 12-bit unsigned arithmetic.
REQ-010 hit SHALL be evaluated only in PLAY; it is ignored in IDLE and DEAD.
REQ-011 In PLAY, passColumn=1 with hit=0 SHALL increment score by 1 in BCD on that edge.
- Each digit carries 9->0.
- 9999 wraps to 0000.
REQ-012 passColumn and hit in the same cycle: hit wins; the edge enters DEAD and score is unchanged.
REQ-013 passColumn outside PLAY SHALL be ignored.
REQ-014 start while in PLAY SHALL be ignored.
REQ-015 Latency: collision, finished and score update one gameClk edge after the causing inputs are sampled.

Reset
REQ-016 Asserting reset SHALL immediately force the following, regardless of current state, including mid-game:
- state=IDLE
- score=0000
- highScore=0000
- collision=0
- finished=0
- playing=0
REQ-017 The first start after reset is released SHALL behave per REQ-004.

Configuration
REQ-018 Macro COLLISION_SCORE_HIGHSCORE_EN SHALL control high-score tracking.
REQ-019 Defined: on each PLAY->DEAD edge, if score > highScore (BCD compare, MS digit first), highScore takes score on that edge.
REQ-020 Undefined: highScore is tied to 16'h0000 and no high-score register is synthesized.

Verification
REQ-021 Reset mid-PLAY with score=0012 -> same cycle state=IDLE, score=0000, highScore=0000, finished=0.
REQ-022 start, then 3 passColumn pulses with birdY=200, Ax=Bx=600 -> score=0003, playing=1, collision=0.
REQ-023 PLAY, Ax=250, Ay=300, birdY=100 -> next edge: collision=1, finished=1, score held.
REQ-024 PLAY, Ax=250, Ay=300, birdY=280 (inside gap) -> no collision.
REQ-025 PLAY, birdY=464 -> floor hit, finished=1.
REQ-026 Score 0099 plus passColumn and hit in the same cycle -> DEAD with score=0099, highScore=0099 (with macro) or 0000 (without).
